// File: rtl/reorder_buffer_pkg.sv
// Shared widths and the per-entry payload record for the reorder buffer.
// Tag width and depth defaults live here so the bench and the RTL agree.
package reorder_buffer_pkg;
    localparam int DEF_ROB_DEPTH = 16;
    localparam int DEF_ROB_WIDTH = 4;
    localparam int IDWidth       = 32;
    localparam int RegWidth      = 5;
    localparam int AddressWidth  = 32;
    localparam int InstTypeWidth = 6;

    // Status bits (busy/ready) are kept outside the record because they are reset.
    typedef struct packed {
        logic [InstTypeWidth-1:0] opcode;
        logic [RegWidth-1:0]      dest;
        logic [AddressWidth-1:0]  pc;
        logic [IDWidth-1:0]       value;
        logic                     mispredict;
        logic [AddressWidth-1:0]  target;
    } rob_entry_t;
endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags to dispatched instructions, captures
// CDB results, answers operand queries and retires in order with flush on mispredict.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_DEPTH = DEF_ROB_DEPTH,
    parameter int ROBWidth  = DEF_ROB_WIDTH
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,
    input  logic                     dispatcher_rob_en_in,
    input  logic [InstTypeWidth-1:0] dispatcher_rob_opcode_in,
    input  logic [RegWidth-1:0]      dispatcher_rob_dest_in,
    input  logic [AddressWidth-1:0]  dispatcher_rob_pc_in,
    output logic [ROBWidth-1:0]      rob_dispatcher_b_out,
    output logic                     rob_full_out,
    input  logic [ROBWidth-1:0]      dispatcher_rob_rs_h_in,
    input  logic [ROBWidth-1:0]      dispatcher_rob_rt_h_in,
    output logic                     rob_dispatcher_rs_ready_out,
    output logic                     rob_dispatcher_rt_ready_out,
    output logic [IDWidth-1:0]       rob_dispatcher_rs_value_out,
    output logic [IDWidth-1:0]       rob_dispatcher_rt_value_out,
    input  logic                     cdb_en_in,
    input  logic [ROBWidth-1:0]      cdb_tag_in,
    input  logic [IDWidth-1:0]       cdb_value_in,
    input  logic                     cdb_mispredict_in,
    input  logic [AddressWidth-1:0]  cdb_target_in,
    output logic                     rob_regfile_en_out,
    output logic [RegWidth-1:0]      rob_regfile_rd_out,
    output logic [IDWidth-1:0]       rob_regfile_value_out,
    output logic [ROBWidth-1:0]      rob_regfile_reorder_out,
    output logic                     rob_flush_out,
    output logic [AddressWidth-1:0]  rob_flush_pc_out
);
    localparam logic [ROBWidth-1:0] FIRST_TAG = ROBWidth'(1);
    localparam logic [ROBWidth-1:0] LAST_TAG  = ROBWidth'(ROB_DEPTH - 1);

    rob_entry_t           entry [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] busy;
    logic [ROB_DEPTH-1:0] ready;
    logic [ROBWidth-1:0]  head;
    logic [ROBWidth-1:0]  tail;
    logic [ROBWidth-1:0]  count;
    logic                 do_alloc;
    logic                 do_cdb;
    logic                 do_commit;
    logic                 do_flush;

    // Slot 0 is reserved as the "no dependence" tag, so pointers wrap to 1.
    function automatic logic [ROBWidth-1:0] next_ptr(input logic [ROBWidth-1:0] p);
        return (p == LAST_TAG) ? FIRST_TAG : p + FIRST_TAG;
    endfunction

    function automatic logic [IDWidth:0] lookup(input logic [ROBWidth-1:0] h);
        logic [IDWidth:0] r;
        r = '0;
        if (h != '0 && busy[h]) begin
            if (cdb_en_in && cdb_tag_in == h)
                r = {1'b1, cdb_value_in};
            else if (ready[h])
                r = {1'b1, entry[h].value};
        end
        return r;
    endfunction

    assign rob_full_out         = (count == LAST_TAG);
    assign rob_dispatcher_b_out = tail;
    assign do_alloc  = rdy_in && dispatcher_rob_en_in && !rob_full_out;
    assign do_cdb    = rdy_in && cdb_en_in && (cdb_tag_in != '0) && busy[cdb_tag_in];
    assign do_commit = rdy_in && busy[head] && ready[head];
    assign do_flush  = do_commit && entry[head].mispredict;

    always_comb begin
        {rob_dispatcher_rs_ready_out, rob_dispatcher_rs_value_out} = lookup(dispatcher_rob_rs_h_in);
        {rob_dispatcher_rt_ready_out, rob_dispatcher_rt_value_out} = lookup(dispatcher_rob_rt_h_in);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy                    <= '0;
            ready                   <= '0;
            head                    <= FIRST_TAG;
            tail                    <= FIRST_TAG;
            count                   <= '0;
            rob_regfile_en_out      <= 1'b0;
            rob_regfile_rd_out      <= '0;
            rob_regfile_value_out   <= '0;
            rob_regfile_reorder_out <= '0;
            rob_flush_out           <= 1'b0;
            rob_flush_pc_out        <= '0;
        end else begin
            rob_regfile_en_out <= do_commit && (entry[head].dest != '0);
            rob_flush_out      <= do_flush;
            if (do_commit) begin
                rob_regfile_rd_out      <= entry[head].dest;
                rob_regfile_value_out   <= entry[head].value;
                rob_regfile_reorder_out <= head;
            end
            if (do_flush)
                rob_flush_pc_out <= entry[head].target;

            // A retiring mispredict wipes everything younger, including this cycle's alloc/CDB.
            if (do_flush) begin
                busy  <= '0;
                ready <= '0;
                head  <= FIRST_TAG;
                tail  <= FIRST_TAG;
                count <= '0;
            end else begin
                if (do_cdb)
                    ready[cdb_tag_in] <= 1'b1;
                if (do_commit) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= next_ptr(head);
                end
                if (do_alloc) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= next_ptr(tail);
                end
                if (do_alloc && !do_commit)
                    count <= count + FIRST_TAG;
                else if (!do_alloc && do_commit)
                    count <= count - FIRST_TAG;
            end
        end
    end

    // Payload needs no reset: it is only ever read behind a set busy bit.
    always_ff @(posedge clk_in) begin
        if (!do_flush) begin
            if (do_alloc)
                entry[tail] <= '{opcode:     dispatcher_rob_opcode_in,
                                 dest:       dispatcher_rob_dest_in,
                                 pc:         dispatcher_rob_pc_in,
                                 value:      '0,
                                 mispredict: 1'b0,
                                 target:     '0};
            if (do_cdb) begin
                entry[cdb_tag_in].value      <= cdb_value_in;
                entry[cdb_tag_in].mispredict <= cdb_mispredict_in;
                entry[cdb_tag_in].target     <= cdb_target_in;
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed vector table, hand-written wrap/reset
// sequences, then random traffic against a queue-based program-order model.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int RW    = DEF_ROB_WIDTH;
    localparam int DEPTH = DEF_ROB_DEPTH;

    logic                     clk_in, rst_n_in, rdy_in;
    logic                     dispatcher_rob_en_in;
    logic [InstTypeWidth-1:0] dispatcher_rob_opcode_in;
    logic [RegWidth-1:0]      dispatcher_rob_dest_in;
    logic [AddressWidth-1:0]  dispatcher_rob_pc_in;
    logic [RW-1:0]            rob_dispatcher_b_out;
    logic                     rob_full_out;
    logic [RW-1:0]            dispatcher_rob_rs_h_in, dispatcher_rob_rt_h_in;
    logic                     rob_dispatcher_rs_ready_out, rob_dispatcher_rt_ready_out;
    logic [IDWidth-1:0]       rob_dispatcher_rs_value_out, rob_dispatcher_rt_value_out;
    logic                     cdb_en_in;
    logic [RW-1:0]            cdb_tag_in;
    logic [IDWidth-1:0]       cdb_value_in;
    logic                     cdb_mispredict_in;
    logic [AddressWidth-1:0]  cdb_target_in;
    logic                     rob_regfile_en_out;
    logic [RegWidth-1:0]      rob_regfile_rd_out;
    logic [IDWidth-1:0]       rob_regfile_value_out;
    logic [RW-1:0]            rob_regfile_reorder_out;
    logic                     rob_flush_out;
    logic [AddressWidth-1:0]  rob_flush_pc_out;

    reorder_buffer #(.ROB_DEPTH(DEPTH), .ROBWidth(RW)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .dispatcher_rob_en_in(dispatcher_rob_en_in),
        .dispatcher_rob_opcode_in(dispatcher_rob_opcode_in),
        .dispatcher_rob_dest_in(dispatcher_rob_dest_in),
        .dispatcher_rob_pc_in(dispatcher_rob_pc_in),
        .rob_dispatcher_b_out(rob_dispatcher_b_out),
        .rob_full_out(rob_full_out),
        .dispatcher_rob_rs_h_in(dispatcher_rob_rs_h_in),
        .dispatcher_rob_rt_h_in(dispatcher_rob_rt_h_in),
        .rob_dispatcher_rs_ready_out(rob_dispatcher_rs_ready_out),
        .rob_dispatcher_rt_ready_out(rob_dispatcher_rt_ready_out),
        .rob_dispatcher_rs_value_out(rob_dispatcher_rs_value_out),
        .rob_dispatcher_rt_value_out(rob_dispatcher_rt_value_out),
        .cdb_en_in(cdb_en_in), .cdb_tag_in(cdb_tag_in), .cdb_value_in(cdb_value_in),
        .cdb_mispredict_in(cdb_mispredict_in), .cdb_target_in(cdb_target_in),
        .rob_regfile_en_out(rob_regfile_en_out),
        .rob_regfile_rd_out(rob_regfile_rd_out),
        .rob_regfile_value_out(rob_regfile_value_out),
        .rob_regfile_reorder_out(rob_regfile_reorder_out),
        .rob_flush_out(rob_flush_out),
        .rob_flush_pc_out(rob_flush_pc_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int en, input int dest, input int cen, input int ctag,
                         input int unsigned cval, input int mis, input int unsigned tgt,
                         input int rs, input int rt);
        dispatcher_rob_en_in     = 1'(en);
        dispatcher_rob_opcode_in = InstTypeWidth'(dest + 3);
        dispatcher_rob_dest_in   = RegWidth'(dest);
        dispatcher_rob_pc_in     = AddressWidth'(32'h400 + 4 * dest);
        cdb_en_in                = 1'(cen);
        cdb_tag_in               = RW'(ctag);
        cdb_value_in             = IDWidth'(cval);
        cdb_mispredict_in        = 1'(mis);
        cdb_target_in            = AddressWidth'(tgt);
        dispatcher_rob_rs_h_in   = RW'(rs);
        dispatcher_rob_rt_h_in   = RW'(rt);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tagname);
        chk({tagname, " b"},       rob_dispatcher_b_out, 1);
        chk({tagname, " full"},    rob_full_out, 0);
        chk({tagname, " ren"},     rob_regfile_en_out, 0);
        chk({tagname, " rd"},      rob_regfile_rd_out, 0);
        chk({tagname, " rval"},    rob_regfile_value_out, 0);
        chk({tagname, " reorder"}, rob_regfile_reorder_out, 0);
        chk({tagname, " flush"},   rob_flush_out, 0);
        chk({tagname, " fpc"},     rob_flush_pc_out, 0);
        chk({tagname, " rs_rdy"},  rob_dispatcher_rs_ready_out, 0);
        chk({tagname, " rs_val"},  rob_dispatcher_rs_value_out, 0);
    endtask

    task automatic do_reset();
        rdy_in = 1'b1;
        idle();
        dispatcher_rob_rs_h_in = RW'(3);
        rst_n_in = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int en, dest, cen, ctag, cval, mis, tgt, rs, rt;
        int b, full, rsr, rsv, rtr, rtv;
        int ren, rd, rv, rtg, fl, fpc;
    } vec_t;

    vec_t vecs[20];

    // ---------------- program-order reference model ----------------
    typedef struct {
        int          tag;
        int          dest;
        bit          rdy;
        logic [31:0] val;
        bit          mis;
        logic [31:0] tgt;
    } ment_t;

    ment_t mq[$];
    int    mtail;

    task automatic mquery(input int h, input bit cen, input int ctag, input logic [31:0] cval,
                          output bit r, output logic [31:0] v);
        r = 0;
        v = '0;
        if (h != 0)
            foreach (mq[k])
                if (mq[k].tag == h) begin
                    if (cen && ctag == h) begin r = 1; v = cval; end
                    else if (mq[k].rdy) begin r = 1; v = mq[k].val; end
                end
    endtask

    task automatic mstep(input bit rdy, input bit en, input int dest, input bit cen, input int ctag,
                         input logic [31:0] cval, input bit mis, input logic [31:0] tgt,
                         output bit ren, output int rd, output logic [31:0] rv, output int rtag,
                         output bit fl, output logic [31:0] fpc);
        bit was_full, commit;
        ren = 0; rd = 0; rv = '0; rtag = 0; fl = 0; fpc = '0;
        if (!rdy) return;
        was_full = (mq.size() == DEPTH - 1);
        commit   = (mq.size() > 0) && mq[0].rdy;
        if (commit) begin
            ren  = (mq[0].dest != 0);
            rd   = mq[0].dest;
            rv   = mq[0].val;
            rtag = mq[0].tag;
            fl   = mq[0].mis;
            fpc  = mq[0].tgt;
        end
        if (fl) begin
            mq.delete();
            mtail = 1;
            return;
        end
        if (cen && ctag != 0)
            foreach (mq[k])
                if (mq[k].tag == ctag) begin
                    mq[k].rdy = 1; mq[k].val = cval; mq[k].mis = mis; mq[k].tgt = tgt;
                end
        if (commit) void'(mq.pop_front());
        if (en && !was_full) begin
            mq.push_back('{tag: mtail, dest: dest, rdy: 0, val: '0, mis: 0, tgt: '0});
            mtail = (mtail == DEPTH - 1) ? 1 : mtail + 1;
        end
    endtask

    initial begin
        // en dest cen ctag cval mis tgt rs rt | b full rsr rsv rtr rtv | ren rd rv rtg fl fpc
        vecs[0]  = '{1,1, 0,0,0,0,0, 0,0,  1,0, 0,0,0,0,             0,0,0,0, 0,0};
        vecs[1]  = '{1,2, 0,0,0,0,0, 0,0,  2,0, 0,0,0,0,             0,0,0,0, 0,0};
        vecs[2]  = '{1,0, 0,0,0,0,0, 0,0,  3,0, 0,0,0,0,             0,0,0,0, 0,0};
        vecs[3]  = '{0,0, 1,3,'h33,0,0, 3,1, 4,0, 1,'h33,0,0,        0,0,0,0, 0,0};
        vecs[4]  = '{0,0, 1,2,'hDEAD,0,0, 2,3, 4,0, 1,'hDEAD,1,'h33, 0,0,0,0, 0,0};
        vecs[5]  = '{0,0, 1,1,'h11,0,0, 1,0, 4,0, 1,'h11,0,0,        0,0,0,0, 0,0};
        vecs[6]  = '{0,0, 0,0,0,0,0, 1,2,  4,0, 1,'h11,1,'hDEAD,     1,1,'h11,1, 0,0};
        vecs[7]  = '{0,0, 0,0,0,0,0, 1,3,  4,0, 0,0,1,'h33,          1,2,'hDEAD,2, 0,0};
        vecs[8]  = '{0,0, 0,0,0,0,0, 0,0,  4,0, 0,0,0,0,             0,0,0,0, 0,0};
        vecs[9]  = '{1,4, 0,0,0,0,0, 0,0,  4,0, 0,0,0,0,             0,0,0,0, 0,0};
        vecs[10] = '{1,0, 0,0,0,0,0, 4,0,  5,0, 0,0,0,0,             0,0,0,0, 0,0};
        vecs[11] = '{1,6, 0,0,0,0,0, 0,0,  6,0, 0,0,0,0,             0,0,0,0, 0,0};
        vecs[12] = '{0,0, 1,5,'h55,1,'h1000, 5,0, 7,0, 1,'h55,0,0,   0,0,0,0, 0,0};
        vecs[13] = '{0,0, 1,4,'h44,0,0, 6,5, 7,0, 0,0,1,'h55,        0,0,0,0, 0,0};
        vecs[14] = '{0,0, 0,0,0,0,0, 0,0,  7,0, 0,0,0,0,             1,4,'h44,4, 0,0};
        vecs[15] = '{1,8, 0,0,0,0,0, 6,0,  7,0, 0,0,0,0,             0,0,0,0, 1,'h1000};
        vecs[16] = '{0,0, 1,6,'h1,0,0, 6,0, 1,0, 0,0,0,0,            0,0,0,0, 0,0};
        vecs[17] = '{0,0, 0,0,0,0,0, 6,0,  1,0, 0,0,0,0,             0,0,0,0, 0,0};
        vecs[18] = '{1,9, 0,0,0,0,0, 0,0,  1,0, 0,0,0,0,             0,0,0,0, 0,0};
        vecs[19] = '{0,0, 0,0,0,0,0, 1,0,  2,0, 0,0,0,0,             0,0,0,0, 0,0};

        rst_n_in = 1'b1;
        rdy_in   = 1'b1;
        idle();
        #2;
        do_reset();

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].dest, vecs[i].cen, vecs[i].ctag, vecs[i].cval,
                  vecs[i].mis, vecs[i].tgt, vecs[i].rs, vecs[i].rt);
            @(negedge clk_in);
            chk($sformatf("v%0d b", i),      rob_dispatcher_b_out, vecs[i].b);
            chk($sformatf("v%0d full", i),   rob_full_out, vecs[i].full);
            chk($sformatf("v%0d rs_rdy", i), rob_dispatcher_rs_ready_out, vecs[i].rsr);
            chk($sformatf("v%0d rs_val", i), rob_dispatcher_rs_value_out, vecs[i].rsv);
            chk($sformatf("v%0d rt_rdy", i), rob_dispatcher_rt_ready_out, vecs[i].rtr);
            chk($sformatf("v%0d rt_val", i), rob_dispatcher_rt_value_out, vecs[i].rtv);
            @(posedge clk_in);
            #1;
            chk($sformatf("v%0d ren", i),   rob_regfile_en_out, vecs[i].ren);
            chk($sformatf("v%0d flush", i), rob_flush_out, vecs[i].fl);
            if (vecs[i].ren != 0) begin
                chk($sformatf("v%0d rd", i),   rob_regfile_rd_out, vecs[i].rd);
                chk($sformatf("v%0d rval", i), rob_regfile_value_out, vecs[i].rv);
                chk($sformatf("v%0d rtag", i), rob_regfile_reorder_out, vecs[i].rtg);
            end
            if (vecs[i].fl != 0)
                chk($sformatf("v%0d fpc", i), rob_flush_pc_out, vecs[i].fpc);
        end

        // ---- fill to full, ignored enable, commit does not unblock same cycle, wrap ----
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) begin
            drive(1, i + 1, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk_in);
            chk($sformatf("fill%0d b", i), rob_dispatcher_b_out, i + 1);
            chk($sformatf("fill%0d full", i), rob_full_out, 0);
            @(posedge clk_in);
            #1;
        end
        drive(1, 5, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_in);
        chk("full flag", rob_full_out, 1);
        chk("full b", rob_dispatcher_b_out, 1);
        @(posedge clk_in);
        #1;
        drive(0, 0, 1, 1, 'hA1, 0, 0, 0, 0);
        @(posedge clk_in);
        #1;
        drive(1, 7, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_in);
        chk("commit-cycle full", rob_full_out, 1);
        @(posedge clk_in);
        #1;
        chk("wrap commit ren", rob_regfile_en_out, 1);
        chk("wrap commit rd", rob_regfile_rd_out, 1);
        chk("wrap commit val", rob_regfile_value_out, 'hA1);
        chk("wrap commit tag", rob_regfile_reorder_out, 1);
        chk("after commit full", rob_full_out, 0);
        chk("after commit b", rob_dispatcher_b_out, 1);
        drive(1, 7, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk_in);
        #1;
        chk("wrap alloc b", rob_dispatcher_b_out, 2);
        chk("wrap alloc full", rob_full_out, 1);

        // ---- reset mid-flight while a commit strobe is high ----
        drive(0, 0, 1, 2, 'hB2, 0, 0, 0, 0);
        @(posedge clk_in);
        #1;
        idle();
        dispatcher_rob_rs_h_in = RW'(3);
        @(posedge clk_in);
        #1;
        chk("pre-reset ren", rob_regfile_en_out, 1);
        rst_n_in = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        drive(1, 3, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_in);
        chk("post-reset b", rob_dispatcher_b_out, 1);
        @(posedge clk_in);
        #1;
        chk("post-reset b next", rob_dispatcher_b_out, 2);

        // ---- random traffic against the model ----
        do_reset();
        mq.delete();
        mtail = 1;
        for (int c = 0; c < 3000; c++) begin
            bit          r_rdy, r_en, r_cen, r_mis;
            int          r_dest, r_ctag, r_rs, r_rt;
            logic [31:0] r_cval, r_tgt;
            bit          er, eren, efl;
            logic [31:0] ev, erv, efpc;
            int          erd, ertag;
            r_rdy  = ($urandom_range(0, 9) != 0);
            r_en   = ($urandom_range(0, 2) != 0);
            r_dest = $urandom_range(0, 3);
            r_cen  = ($urandom_range(0, 2) != 0);
            r_ctag = (mq.size() > 0 && $urandom_range(0, 3) != 0)
                     ? mq[$urandom_range(0, mq.size() - 1)].tag : $urandom_range(0, DEPTH - 1);
            r_cval = $urandom;
            r_mis  = ($urandom_range(0, 15) == 0);
            r_tgt  = $urandom;
            r_rs   = (mq.size() > 0 && $urandom_range(0, 1) != 0)
                     ? mq[$urandom_range(0, mq.size() - 1)].tag : $urandom_range(0, DEPTH - 1);
            r_rt   = $urandom_range(0, DEPTH - 1);
            rdy_in = r_rdy;
            drive(r_en, r_dest, r_cen, r_ctag, r_cval, r_mis, r_tgt, r_rs, r_rt);
            @(negedge clk_in);
            chk("rnd b", rob_dispatcher_b_out, mtail);
            chk("rnd full", rob_full_out, (mq.size() == DEPTH - 1));
            mquery(r_rs, r_cen, r_ctag, r_cval, er, ev);
            chk("rnd rs_rdy", rob_dispatcher_rs_ready_out, er);
            chk("rnd rs_val", rob_dispatcher_rs_value_out, ev);
            mquery(r_rt, r_cen, r_ctag, r_cval, er, ev);
            chk("rnd rt_rdy", rob_dispatcher_rt_ready_out, er);
            chk("rnd rt_val", rob_dispatcher_rt_value_out, ev);
            mstep(r_rdy, r_en, r_dest, r_cen, r_ctag, r_cval, r_mis, r_tgt,
                  eren, erd, erv, ertag, efl, efpc);
            @(posedge clk_in);
            #1;
            chk("rnd ren", rob_regfile_en_out, eren);
            chk("rnd flush", rob_flush_out, efl);
            if (eren) begin
                chk("rnd rd", rob_regfile_rd_out, erd);
                chk("rnd rval", rob_regfile_value_out, erv);
                chk("rnd rtag", rob_regfile_reorder_out, ertag);
            end
            if (efl)
                chk("rnd fpc", rob_flush_pc_out, efpc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
